// File: rtl/pool_writer.sv
// Streaming sink: writes every convolution result to layer-0 and 2x2/stride-2
// max-pooled results to layer-1 through one shared memory write port.
module pool_writer #(
   parameter int DATA_W = 19,
   parameter int IMG_W  = 64,
   parameter int IMG_H  = 64,
   parameter int CH     = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pool_en,
   input  logic              i_valid,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_ready,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_wr,
   output logic [11:0]       o_addr,
   output logic [19:0]       o_data,
   output logic [2:0]        o_sel
);

   localparam int CW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int CHW = (CH > 1) ? $clog2(CH) : 1;
   localparam int LBN = (IMG_W / 2) * CH;
   localparam int LBW = (LBN > 1) ? $clog2(LBN) : 1;

   typedef enum logic [1:0] {IDLE, RUN, POOLW} state_t;

   state_t            state_q, state_d;
   logic [CHW-1:0]    ch_q, ch_d;
   logic [CW-1:0]     c_q, c_d;
   logic [RW-1:0]     r_q, r_d;
   logic              pool_en_q, pool_en_d;

   logic [DATA_W-1:0] hold_q [CH];
   logic [DATA_W-1:0] lb_q [LBN];

   logic [11:0]       pool_addr_q, pool_addr_d;
   logic [DATA_W-1:0] pool_data_q, pool_data_d;
   logic [2:0]        pool_sel_q, pool_sel_d;
   logic              pool_last_q, pool_last_d;

   logic              wr_q, wr_d;
   logic [11:0]       addr_q, addr_d;
   logic [19:0]       data_q, data_d;
   logic [2:0]        sel_q, sel_d;
   logic              done_q, done_d;
   logic              ready_q, ready_d;
   logic              busy_q, busy_d;

   logic              xfer, pool_on, last_smp;
   logic              hold_we, lb_we;
   logic [LBW-1:0]    lb_idx;
   logic [DATA_W-1:0] hold_rd, lb_rd, pair_max, win_max;

   assign o_ready = ready_q;
   assign o_busy  = busy_q;
   assign o_done  = done_q;
   assign o_wr    = wr_q;
   assign o_addr  = addr_q;
   assign o_data  = data_q;
   assign o_sel   = sel_q;

   always_comb begin
      xfer     = i_valid && ready_q;
      // pool_en is only honoured on the first sample of a frame
      pool_on  = (state_q == IDLE) ? pool_en : pool_en_q;
      last_smp = (ch_q == CHW'(CH - 1)) && (c_q == CW'(IMG_W - 1)) && (r_q == RW'(IMG_H - 1));
      lb_idx   = LBW'((c_q >> 1) * CH + ch_q);
      hold_rd  = hold_q[ch_q];
      lb_rd    = lb_q[lb_idx];
      pair_max = (hold_rd > i_data) ? hold_rd : i_data;
      win_max  = (lb_rd > pair_max) ? lb_rd : pair_max;
   end

   always_comb begin
      state_d     = state_q;
      ch_d        = ch_q;
      c_d         = c_q;
      r_d         = r_q;
      pool_en_d   = pool_en_q;
      pool_addr_d = pool_addr_q;
      pool_data_d = pool_data_q;
      pool_sel_d  = pool_sel_q;
      pool_last_d = pool_last_q;
      wr_d        = 1'b0;
      addr_d      = addr_q;
      data_d      = data_q;
      sel_d       = sel_q;
      done_d      = 1'b0;
      ready_d     = 1'b1;
      busy_d      = done_q ? 1'b0 : busy_q;
      hold_we     = 1'b0;
      lb_we       = 1'b0;

      if (state_q == POOLW) begin
         wr_d    = 1'b1;
         addr_d  = pool_addr_q;
         data_d  = 20'(pool_data_q);
         sel_d   = pool_sel_q;
         done_d  = pool_last_q;
         state_d = pool_last_q ? IDLE : RUN;
      end

      // o_ready is low throughout POOLW, so a transfer never meets a pool write
      if (xfer) begin
         busy_d = 1'b1;
         if (state_q == IDLE)
            pool_en_d = pool_en;
         state_d = RUN;
         wr_d    = 1'b1;
         addr_d  = 12'(r_q * IMG_W + c_q);
         data_d  = 20'(i_data);
         sel_d   = 3'(ch_q + 1);

         if (ch_q == CHW'(CH - 1)) begin
            ch_d = '0;
            if (c_q == CW'(IMG_W - 1)) begin
               c_d = '0;
               r_d = (r_q == RW'(IMG_H - 1)) ? '0 : r_q + 1'b1;
            end else begin
               c_d = c_q + 1'b1;
            end
         end else begin
            ch_d = ch_q + 1'b1;
         end

         if (pool_on) begin
            if (!c_q[0]) begin
               hold_we = 1'b1;
            end else if (!r_q[0]) begin
               lb_we = 1'b1;
            end else begin
               pool_addr_d = 12'((r_q >> 1) * (IMG_W / 2) + (c_q >> 1));
               pool_data_d = win_max;
               pool_sel_d  = 3'(CH + 1 + ch_q);
               pool_last_d = last_smp;
               ready_d     = 1'b0;
               state_d     = POOLW;
            end
         end else if (last_smp) begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         ch_q        <= '0;
         c_q         <= '0;
         r_q         <= '0;
         pool_en_q   <= 1'b0;
         pool_addr_q <= '0;
         pool_data_q <= '0;
         pool_sel_q  <= '0;
         pool_last_q <= 1'b0;
         wr_q        <= 1'b0;
         addr_q      <= '0;
         data_q      <= '0;
         sel_q       <= '0;
         done_q      <= 1'b0;
         ready_q     <= 1'b1;
         busy_q      <= 1'b0;
         for (int unsigned k = 0; k < CH; k++)
            hold_q[k] <= '0;
      end else begin
         state_q     <= state_d;
         ch_q        <= ch_d;
         c_q         <= c_d;
         r_q         <= r_d;
         pool_en_q   <= pool_en_d;
         pool_addr_q <= pool_addr_d;
         pool_data_q <= pool_data_d;
         pool_sel_q  <= pool_sel_d;
         pool_last_q <= pool_last_d;
         wr_q        <= wr_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         sel_q       <= sel_d;
         done_q      <= done_d;
         ready_q     <= ready_d;
         busy_q      <= busy_d;
         if (hold_we)
            hold_q[ch_q] <= i_data;
      end
   end

   always_ff @(posedge clk) begin
      if (lb_we)
         lb_q[lb_idx] <= pair_max;
   end

endmodule

// File: doc/pool_writer.md
# pool_writer

Parametrised streaming sink between the convolution engine and the shared layer memory. It writes every convolution result to its layer-0 bank. It also computes 2×2 stride-2 max-pooling per channel and writes the pooled results to the layer-1 bank. Both streams share one memory write port; a ready handshake throttles the producer, and the block signals frame completion.

## Interface
- DATA_W, 19: result width, unsigned, 1..20.
- IMG_W, 64: image width in pixels, even; IMG_W*IMG_H ≤ 4096.
- IMG_H, 64: image height in pixels, even.
- CH, 2: number of interleaved channels (kernels), 1..3.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- pool_en  in  1  enable pooling; sampled on the first accepted sample of a frame and held for that frame.
- i_valid  in  1  input sample valid.
- i_data  in  DATA_W  convolution result, unsigned.
- o_ready  out  1  registered; a sample transfers when i_valid && o_ready.
- o_busy  out  1  frame in progress.
- o_done  out  1  one-cycle pulse coincident with the final write of a frame.
- o_wr  out  1  memory write strobe.
- o_addr  out  12  memory address.
- o_data  out  20  write data; i_data zero-extended to 20 bits.
- o_sel  out  3  bank select: layer-0 channel k = 1+k; layer-1 channel k = 1+CH+k.

## Operation
- Stream order is raster (row r, column c). For each pixel, CH samples arrive in order ch = 0..CH-1.
- Counters ch, c, r advance on each transfer. At the frame end they wrap to 0.
- **Layer-0 write:** each transfer produces a write with addr = r*IMG_W + c, sel = 1+ch, data = sample.
- **Pooling (pool_en=1):** compares are unsigned.
  - Even row, even column: store the sample in a column-hold register, one per channel.
  - Even row, odd column: write max(hold, sample) to a line buffer, IMG_W/2 × CH entries, indexed [c/2][ch].
  - Odd row, even column: store the sample in the column-hold register.
  - Odd row, odd column (a "completing" sample): pooled = max(linebuf[c/2][ch], hold, sample). It is written with addr = (r/2)*(IMG_W/2) + c/2, sel = 1+CH+ch.
- **pool_en=0:** no layer-1 writes, o_ready stays 1, and line-buffer contents are don't-care.
- **FSM:**
  - IDLE (o_busy=0). The first transfer goes to RUN, latches pool_en, and sets o_busy=1.
  - RUN → POOLW on a completing transfer.
  - POOLW lasts one cycle, then returns to RUN.
  - After the final write the FSM returns to IDLE.
- **Final write:**
  - pool_en=1: the pool write of sample (IMG_H-1, IMG_W-1, CH-1).
  - pool_en=0: the layer-0 write of that sample.

## Timing
- **Reset values:** o_wr=0, o_addr=0, o_data=0, o_sel=0, o_busy=0, o_done=0, o_ready=1. Counters, hold registers and FSM are cleared. Line-buffer contents are don't-care.
- **Layer-0 write latency:** a transfer at cycle t produces o_wr=1 with its address, data and sel at t+1.
- **Completing sample accepted at t:**
  - o_ready=0 during t+1, so no transfer can occur at t+1.
  - The layer-0 write occurs at t+1.
  - The pool write occurs at t+2.
  - o_ready=1 again at t+2.
- Exactly one write per cycle; layer-0 and pool writes never collide.
- o_wr=0 in any cycle with no write. o_addr, o_data and o_sel hold their last values.
- Gaps with i_valid=0 are allowed anywhere. State is held and pending writes still issue.
- **Frame end:**
  - o_done=1 in the same cycle as the final o_wr.
  - o_busy falls the next cycle.
  - A new frame may transfer in the cycle after o_done.
- Reset mid-frame returns all outputs to their reset values immediately (asynchronously). The next frame restarts at address 0. A pending pool write is discarded.
- Throughput: 1 sample/cycle with pool_en=0. With pool_en=1, one bubble per completing sample.

## Test plan
Defaults: DATA_W=19, IMG_W=IMG_H=64, CH=2.

- **Reset:** assert reset with stimulus active → all outputs equal their reset values, including o_ready=1, within the same cycle.
- **Single sample:** first sample 0x00005 on ch0 → next cycle o_wr=1, o_addr=0, o_sel=1, o_data=0x00005; o_busy=1.
- **Pooling window:** ch0 window values (0,0)=3, (0,1)=9, (1,0)=7, (1,1)=4; ch1 window 2, 1, 6, 0x7FFFF → pool writes addr 0, sel 3, data 9 and addr 0, sel 4, data 0x7FFFF. o_ready is low for exactly one cycle after each completing transfer. There are four layer-0 writes per channel at addresses 0, 1, 64, 65.
- **Full frame, pool_en=0:** continuous i_valid → 8192 writes, none with sel 3 or 4, no o_ready drops. o_done coincides with addr 4095, sel 2; o_busy falls the next cycle.
- **Full frame, pool_en=1, random gaps:** → 8192 layer-0 writes plus 2048 pool writes matching a reference max model. The last write is addr 1023, sel 4, with o_done=1. Toggling pool_en mid-frame has no effect.
- **Reset mid-frame:** reset after transfer 1000, then a new frame → the first write is addr 0, sel 1, and the pooled values are correct.
